operand_shifter: RTL and testbench
==================================

# operand_shifter

Multi-cycle ARM-style operand shifter that sits directly upstream of the ALU's B operand. It takes a 32-bit operand, a shift type and an 8-bit shift amount, shifts the operand one bit per clock, and returns the shifted operand together with the shifter carry-out. The carry-out feeds the ALU's `shiftCout` input, which the ALU uses for logical-op C-flag updates. A start/done handshake lets the control FSM stall the datapath while a shift is in flight.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `shift_op`  in  3  shift type: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX; 101–111 behave as pass-through.
- `shift_num`  in  8  shift amount, 0–255; ignored for RRX.
- `din`  in  32  operand to shift.
- `C`  in  1  current CPSR carry; used for amount-0 cases and for RRX.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid in this cycle.
- `dout`  out  32  shifted operand; held until the next accepted start.
- `shiftCout`  out  1  shifter carry-out; held with `dout`.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE + start:** latch `din`, `shift_op` and `C`. Compute the step count k:
  - LSL/LSR/ASR: k = min(`shift_num`, 33).
  - ROR: k = `shift_num[4:0]`.
  - RRX: k = 1.
  - Pass-through: k = 0.
  - Next state is SHIFT if k > 0, otherwise DONE.
- **Carry preload at accept:**
  - Default: the preloaded carry is `C`.
  - ROR with `shift_num` ≠ 0 and `shift_num[4:0]` = 0: carry = `din[31]`, `dout` = `din`, and the block goes straight to DONE.
- **One step per SHIFT cycle:**
  - LSL: carry ← d[31], d ← {d[30:0], 0}.
  - LSR: carry ← d[0], d ← {0, d[31:1]}.
  - ASR: carry ← d[0], d ← {d[31], d[31:1]}.
  - ROR: carry ← d[0], d ← {d[0], d[31:1]}.
  - RRX: carry ← d[0], d ← {C_latched, d[31:1]}.
- **Counter:** decrements each step. When the step that makes it 0 completes, go to DONE.
- **DONE:** `done` = 1 for one cycle, then return to IDLE. `dout`/`shiftCout` stay unchanged until the next accept.
- **Resulting ARM semantics:**
  - LSL/LSR by 32: result 0; carry = `din[0]` / `din[31]`.
  - LSL/LSR by more than 32: result 0, carry 0.
  - ASR by 32 or more: result is all copies of the sign bit; carry = sign.
  - Amount 0, any op except RRX: `dout` = `din`, `shiftCout` = `C`.
- **Start handling:** `start` while `busy` is ignored; no queuing.
- **Operand capture:** `din`/`shift_num` may change after the accept edge without effect.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `dout` 0x00000000, `shiftCout` 0, counter 0.
- **Reset mid-operation:** aborts within the same edge. No `done` pulse is produced, and the outputs return to their reset values.
- **Latency:** start accepted at edge t → `done` high in the cycle after edge t+k, i.e. k+1 cycles.
  - Minimum 1 cycle (k = 0).
  - Maximum 34 cycles (LSL/LSR/ASR with amount ≥ 33).
- **busy:** rises in the cycle after the accept edge and falls in the cycle after `done`. `busy` is high during the `done` cycle.
- **Back-to-back shifts:** earliest next accept is in the IDLE cycle following DONE, i.e. a 1-cycle gap.
- **Simultaneous rst and start:** reset wins.

## Structure
- **Shared package:**
  - `SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROR`, `SH_RRX` 3-bit constants.
  - State encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
  - `SH_MAX_STEPS` = 33.
- **Sub-module:** one combinational sub-module, `shift_step`, performs the single-bit step from (d, op, C_latched) to (d_next, carry_next). The FSM, counter and output registers live in `operand_shifter`.
- **Counter width:** 6 bits.

## Test plan
- **LSL by 1:** LSL, `din`=0x80000001, `shift_num`=1 → `dout`=0x00000002, `shiftCout`=1; `done` 2 cycles after the accept edge.
- **LSR by 32, then LSL by 40:** LSR, `din`=0x80000000, `shift_num`=32 → `dout`=0, `shiftCout`=1, latency 33 cycles. Then LSL, `din`=0xFFFFFFFF, `shift_num`=40 → `dout`=0, `shiftCout`=0, latency 34 cycles.
- **ASR and ROR:** ASR, `din`=0x80000000, `shift_num`=200 → `dout`=0xFFFFFFFF, `shiftCout`=1. ROR, `din`=0x0000000F, `shift_num`=4 → `dout`=0xF0000000, `shiftCout`=1. ROR, `din`=0x80000000, `shift_num`=32 → `dout`=0x80000000, `shiftCout`=1, latency 1 cycle.
- **Amount 0 and RRX:** LSL, `shift_num`=0, `C`=1, `din`=0x12345678 → `dout`=0x12345678, `shiftCout`=1, `done` 1 cycle after accept. RRX, `C`=1, `din`=0x00000003 → `dout`=0x80000001, `shiftCout`=1.
- **Start while busy:** pulse `start` with LSL 1 during an LSR-16 shift → ignored; the LSR result is delivered unchanged and `done` pulses exactly once.
- **Reset mid-shift:** assert `rst` at cycle 5 of an ASR-20 shift → next cycle `busy`=0, `dout`=0, `shiftCout`=0, no `done`. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/operand_shifter_pkg.sv
// Shared constants, state encoding and step-count helper for the
// multi-cycle ARM-style operand shifter.
package operand_shifter_pkg;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b001;
    localparam logic [2:0] SH_ASR = 3'b010;
    localparam logic [2:0] SH_ROR = 3'b011;
    localparam logic [2:0] SH_RRX = 3'b100;

    localparam logic [5:0] SH_MAX_STEPS = 6'd33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Shifts beyond 33 produce the same result as 33, so the step count saturates there.
    function automatic logic [5:0] step_count(input logic [2:0] op, input logic [7:0] num);
        logic [5:0] k;
        case (op)
            SH_LSL, SH_LSR, SH_ASR: begin
                if (num > 8'd33) begin
                    k = SH_MAX_STEPS;
                end else begin
                    k = num[5:0];
                end
            end
            SH_ROR:  k = {1'b0, num[4:0]};
            SH_RRX:  k = 6'd1;
            default: k = 6'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/operand_shifter_shift_step.sv
// Combinational single-bit shift step: one LSL/LSR/ASR/ROR/RRX move of the
// working operand and the carry bit it produces.
module shift_step
    import operand_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    input  logic             c_latched,
    input  logic             carry,
    output logic [WIDTH-1:0] d_next,
    output logic             carry_next
);

    // Select the one-bit move for the latched shift type.
    always_comb begin
        d_next     = d;
        carry_next = carry;
        case (op)
            SH_LSL: begin
                carry_next = d[WIDTH-1];
                d_next     = {d[WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
                carry_next = d[0];
                d_next     = {1'b0, d[WIDTH-1:1]};
            end
            SH_ASR: begin
                carry_next = d[0];
                d_next     = {d[WIDTH-1], d[WIDTH-1:1]};
            end
            SH_ROR: begin
                carry_next = d[0];
                d_next     = {d[0], d[WIDTH-1:1]};
            end
            SH_RRX: begin
                carry_next = d[0];
                d_next     = {c_latched, d[WIDTH-1:1]};
            end
            default: begin
                d_next     = d;
                carry_next = carry;
            end
        endcase
    end

endmodule

// File: rtl/operand_shifter.sv
// Multi-cycle operand shifter for the ALU B operand: one bit per clock,
// start/done handshake, result and carry held until the next accepted start.
module operand_shifter
    import operand_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       shift_op,
    input  logic [7:0]       shift_num,
    input  logic [WIDTH-1:0] din,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             shiftCout
);

    state_e           state_r, state_nxt_s;
    logic [5:0]       cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic [2:0]       op_r, op_nxt_s;
    logic             c_lat_r, c_lat_nxt_s;
    logic             busy_r, done_r;
    logic [5:0]       k_s;
    logic             ror_wrap_s;
    logic [WIDTH-1:0] step_d_s;
    logic             step_c_s;

    assign k_s = step_count(shift_op, shift_num);

    // ROR by a non-zero multiple of 32 leaves the operand intact but still reports bit 31 as carry.
    assign ror_wrap_s = (shift_op == SH_ROR) && (shift_num != 8'd0) && (shift_num[4:0] == 5'd0);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_shift_step (
        .d          (data_r),
        .op         (op_r),
        .c_latched  (c_lat_r),
        .carry      (carry_r),
        .d_next     (step_d_s),
        .carry_next (step_c_s)
    );

    // Next-state, counter and datapath update.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        carry_nxt_s = carry_r;
        op_nxt_s    = op_r;
        c_lat_nxt_s = c_lat_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    data_nxt_s  = din;
                    op_nxt_s    = shift_op;
                    c_lat_nxt_s = C;
                    cnt_nxt_s   = k_s;
                    if (ror_wrap_s) begin
                        carry_nxt_s = din[WIDTH-1];
                    end else begin
                        carry_nxt_s = C;
                    end
                    if (k_s != 6'd0) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_nxt_s  = step_d_s;
                carry_nxt_s = step_c_s;
                cnt_nxt_s   = cnt_r - 6'd1;
                if (cnt_r <= 6'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
            data_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            op_r    <= 3'b000;
            c_lat_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
            carry_r <= carry_nxt_s;
            op_r    <= op_nxt_s;
            c_lat_r <= c_lat_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign dout      = data_r;
    assign shiftCout = carry_r;

endmodule

// File: tb/tb_operand_shifter.sv
// Self-checking bench for operand_shifter: vector table plus hand-written
// sequences for busy-start, mid-shift reset and reset/start collision.
module tb_operand_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  shift_op;
    logic [7:0]  shift_num;
    logic [31:0] din;
    logic        C;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        shiftCout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  num;
        logic [31:0] din;
        logic        c;
        logic [31:0] exp_dout;
        logic        exp_cout;
        int          exp_lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    operand_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_op  (shift_op),
        .shift_num (shift_num),
        .din       (din),
        .C         (C),
        .busy      (busy),
        .done      (done),
        .dout      (dout),
        .shiftCout (shiftCout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Accept one shift, wait for done (bounded), then check result, latency and handshake.
    task automatic run_vec(input string nm, input vec_t v);
        int          lat;
        logic [31:0] got_d;
        logic        got_c;
        logic        busy_at_done;
        lat = 0;
        got_d = 32'h0;
        got_c = 1'b0;
        busy_at_done = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        shift_op  = v.op;
        shift_num = v.num;
        din       = v.din;
        C         = v.c;
        @(negedge clk);
        start     = 1'b0;
        din       = ~v.din;
        shift_num = 8'h05;
        C         = ~v.c;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                lat          = i;
                got_d        = dout;
                got_c        = shiftCout;
                busy_at_done = busy;
                break;
            end
        end
        chk({nm, " dout"}, got_d, v.exp_dout);
        chk({nm, " cout"}, {31'h0, got_c}, {31'h0, v.exp_cout});
        chk({nm, " latency"}, lat, v.exp_lat);
        chk({nm, " busy_at_done"}, {31'h0, busy_at_done}, 32'h1);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, {31'h0, done}, 32'h0);
        chk({nm, " busy_falls"}, {31'h0, busy}, 32'h0);
        chk({nm, " dout_held"}, dout, v.exp_dout);
    endtask

    initial begin
        int   done_cnt;
        logic [31:0] cap_d;
        logic        cap_c;

        vecs[0]  = '{3'b000, 8'd1,   32'h80000001, 1'b0, 32'h00000002, 1'b1, 2};
        vecs[1]  = '{3'b001, 8'd32,  32'h80000000, 1'b0, 32'h00000000, 1'b1, 33};
        vecs[2]  = '{3'b000, 8'd40,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 34};
        vecs[3]  = '{3'b010, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 34};
        vecs[4]  = '{3'b011, 8'd4,   32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 5};
        vecs[5]  = '{3'b011, 8'd32,  32'h80000000, 1'b0, 32'h80000000, 1'b1, 1};
        vecs[6]  = '{3'b000, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 1};
        vecs[7]  = '{3'b100, 8'd77,  32'h00000003, 1'b1, 32'h80000001, 1'b1, 2};
        vecs[8]  = '{3'b000, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 33};
        vecs[9]  = '{3'b010, 8'd4,   32'h7000000F, 1'b0, 32'h07000000, 1'b1, 5};
        vecs[10] = '{3'b011, 8'd36,  32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 5};
        vecs[11] = '{3'b101, 8'd5,   32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1};
        vecs[12] = '{3'b001, 8'd33,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 34};
        vecs[13] = '{3'b010, 8'd0,   32'h80000000, 1'b0, 32'h80000000, 1'b0, 1};
        vecs[14] = '{3'b011, 8'd0,   32'hABCD0000, 1'b1, 32'hABCD0000, 1'b1, 1};
        vecs[15] = '{3'b001, 8'd1,   32'h00000001, 1'b0, 32'h00000000, 1'b1, 2};

        rst = 1'b1; start = 1'b0; shift_op = 3'b000; shift_num = 8'd0; din = 32'h0; C = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        chk("reset dout", dout, 32'h0);
        chk("reset cout", {31'h0, shiftCout}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // start pulse while busy must be ignored
        @(negedge clk);
        start = 1'b1; shift_op = 3'b001; shift_num = 8'd16; din = 32'h00018000; C = 1'b0;
        done_cnt = 0; cap_d = 32'h0; cap_c = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin
                start = 1'b1; shift_op = 3'b000; shift_num = 8'd1; din = 32'hFFFFFFFF; C = 1'b1;
            end
            if (done) begin
                done_cnt++;
                cap_d = dout;
                cap_c = shiftCout;
            end
        end
        chk("busy_start done_count", done_cnt, 32'd1);
        chk("busy_start dout", cap_d, 32'h00000001);
        chk("busy_start cout", {31'h0, cap_c}, 32'h1);

        // reset during the fifth shift cycle of ASR 20
        @(negedge clk);
        start = 1'b1; shift_op = 3'b010; shift_num = 8'd20; din = 32'h80000000; C = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid busy_before_rst", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst busy", {31'h0, busy}, 32'h0);
        chk("mid_rst done", {31'h0, done}, 32'h0);
        chk("mid_rst dout", dout, 32'h0);
        chk("mid_rst cout", {31'h0, shiftCout}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("mid_rst no_activity", done_cnt, 32'd0);
        run_vec("after_rst", vecs[0]);

        // reset and start in the same cycle: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; shift_op = 3'b000; shift_num = 8'd1; din = 32'h80000001; C = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("rst_start idle", {31'h0, busy | done}, 32'h0);
        chk("rst_start dout", dout, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
